// File: rtl/mont_red_pkg.sv
// Shared constants and width helpers for the Montgomery reduction pipeline.
// Stage widths shrink by W per step but never below K+1 bits.
package mont_red_pkg;

  localparam int MR_K = 54;
  localparam int MR_W = 24;
  localparam int MR_TAG_W = 4;
  localparam logic [53:0] MR_MOD_DEFAULT = 54'h3FFFFFFF000001;

  function automatic int mont_red_num_stages(input int k, input int w);
    return (k + w - 1) / w;
  endfunction

  function automatic int mont_red_stage_w(
    input int k,
    input int w,
    input int i
  );
    int full;
    if (i == 0) return 2 * k;
    full = 2 * k - i * w + 1;
    return (full > k + 1) ? full : k + 1;
  endfunction

endpackage

// File: rtl/mont_red_step.sv
// One registered Montgomery word step: T' = (T + m*q) >> W, m = -T mod 2^W.
// Relies on q mod 2^W == 1, so no q^-1 multiply is needed for m.
module mont_red_step
  import mont_red_pkg::*;
#(
  parameter int K = MR_K,
  parameter int W = MR_W,
  parameter int TAG_W = MR_TAG_W,
  parameter int IDX = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_adv,
  input  logic             i_valid,
  input  logic [TAG_W-1:0] i_tag,
  input  logic [2*K-1:0]   i_t,
  input  logic [K-1:0]     i_q,
  output logic             o_valid,
  output logic [TAG_W-1:0] o_tag,
  output logic [2*K-1:0]   o_t
);

  localparam int DW = 2 * K;
  localparam int WI = mont_red_stage_w(K, W, IDX - 1);
  localparam int WO = mont_red_stage_w(K, W, IDX);
  localparam int SW = ((WI > K + W) ? WI : K + W) + 1;

  logic [W-1:0]     w_m;
  logic [SW-1:0]    w_sum;
  logic             r_valid;
  logic [TAG_W-1:0] r_tag;
  logic [WO-1:0]    r_t;

  assign w_m = W'(0) - i_t[W-1:0];
  assign w_sum = SW'(i_t) + SW'(w_m) * SW'(i_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_tag <= '0;
      r_t <= '0;
    end else if (i_adv) begin
      r_valid <= i_valid;
      r_tag <= i_tag;
      r_t <= WO'(w_sum >> W);
    end
  end

  assign o_valid = r_valid;
  assign o_tag = r_tag;
  assign o_t = DW'(r_t);

endmodule

// File: rtl/mont_red_pipe.sv
// Pipelined Montgomery reduction T*R^-1 mod q with a hot-swappable modulus.
// Define MONT_RED_MOD_CHECK_EN to reject malformed moduli via mod_err.
module mont_red_pipe
  import mont_red_pkg::*;
#(
  parameter int K = MR_K,
  parameter int W = MR_W,
  parameter int TAG_W = MR_TAG_W,
  parameter logic [K-1:0] MOD_DEFAULT = K'(MR_MOD_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*K-1:0]   in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [K-1:0]     out_data,
  output logic [TAG_W-1:0] out_tag,
  input  logic             mod_wr,
  input  logic [K-1:0]     mod_data,
  output logic             mod_busy
`ifdef MONT_RED_MOD_CHECK_EN
  ,
  output logic             mod_err
`endif
);

  localparam int S = mont_red_num_stages(K, W);
  localparam int DW = 2 * K;

  logic             w_adv;
  logic             w_acc;
  logic             w_empty;
  logic             w_install;
  logic             w_mod_ok;
  logic [S:0]       w_v;
  logic [TAG_W-1:0] w_tg [0:S];
  logic [DW-1:0]    w_t [0:S];
  logic [K:0]       w_ts;
  logic [K-1:0]     w_res;

  logic [K-1:0]     r_mod;
  logic [K-1:0]     r_pend;
  logic             r_busy;
  logic             r_out_vld;
  logic [K-1:0]     r_out_data;
  logic [TAG_W-1:0] r_out_tag;

  assign w_adv = !r_out_vld || out_ready;
  assign in_ready = w_adv && !r_busy && rst_n;
  assign w_acc = in_valid && in_ready;

  assign w_v[0] = w_acc;
  assign w_tg[0] = in_tag;
  assign w_t[0] = in_data;

  for (genvar gi = 1; gi <= S; gi++) begin : g_step
    mont_red_step #(
      .K(K),
      .W(W),
      .TAG_W(TAG_W),
      .IDX(gi)
    ) u_step (
      .clk(clk),
      .rst_n(rst_n),
      .i_adv(w_adv),
      .i_valid(w_v[gi-1]),
      .i_tag(w_tg[gi-1]),
      .i_t(w_t[gi-1]),
      .i_q(r_mod),
      .o_valid(w_v[gi]),
      .o_tag(w_tg[gi]),
      .o_t(w_t[gi])
    );
  end

  // T_S < 2q, so one conditional subtract lands in [0, q)
  assign w_ts = (K+1)'(w_t[S]);
  assign w_res = (w_ts >= {1'b0, r_mod})
               ? K'(w_ts - {1'b0, r_mod})
               : K'(w_ts);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_vld <= 1'b0;
      r_out_data <= '0;
      r_out_tag <= '0;
    end else if (w_adv) begin
      r_out_vld <= w_v[S];
      r_out_data <= w_res;
      r_out_tag <= w_tg[S];
    end
  end

  assign out_valid = r_out_vld;
  assign out_data = r_out_data;
  assign out_tag = r_out_tag;

`ifdef MONT_RED_MOD_CHECK_EN
  logic r_err;

  assign w_mod_ok = (mod_data[W-1:0] == W'(1)) && mod_data[K-1];

  always_ff @(posedge clk) begin
    if (!rst_n) r_err <= 1'b0;
    else r_err <= mod_wr && !w_mod_ok;
  end

  assign mod_err = r_err;
`else
  assign w_mod_ok = 1'b1;
`endif

  // Swap only once nothing is in flight so every op sees one modulus
  assign w_empty = !r_out_vld && !(|w_v[S:1]);
  assign w_install = r_busy && w_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mod <= MOD_DEFAULT;
      r_pend <= MOD_DEFAULT;
      r_busy <= 1'b0;
    end else begin
      if (w_install) r_mod <= r_pend;
      if (mod_wr && w_mod_ok) begin
        r_pend <= mod_data;
        r_busy <= 1'b1;
      end else if (w_install) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign mod_busy = r_busy;

endmodule

// File: tb/tb_mont_red_pipe.sv
// Self-checking bench for mont_red_pipe at K=16, W=8 (S=2, R=2^16).
// Reference: modular inverse of R found by search, then plain mod arithmetic.
module tb_mont_red_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_tag;
  logic        mod_wr;
  logic [15:0] mod_data;
  logic        mod_busy;
`ifdef MONT_RED_MOD_CHECK_EN
  logic        mod_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  longint unsigned mq = 64'h8F01;
  logic [19:0] exp_q [$];

  mont_red_pipe #(
    .K(16),
    .W(8),
    .TAG_W(4),
    .MOD_DEFAULT(16'h8F01)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_tag(in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_tag(out_tag),
    .mod_wr(mod_wr),
    .mod_data(mod_data),
    .mod_busy(mod_busy)
`ifdef MONT_RED_MOD_CHECK_EN
    ,
    .mod_err(mod_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] ref_red(
    input longint unsigned t,
    input longint unsigned q
  );
    longint unsigned rinv;
    longint unsigned x;
    rinv = 0;
    x = 1;
    while (x < q && rinv == 0) begin
      if (((x << 16) % q) == 1) rinv = x;
      x++;
    end
    return 16'(((t % q) * rinv) % q);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_tag = '0;
    out_ready = 1'b1;
    mod_wr = 1'b0;
    mod_data = '0;
    tick;
    tick;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_in_ready: got %b want 0", in_ready);
    end
    n_cmp++;
    if ({out_valid, out_data, out_tag, mod_busy} !== 22'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got v=%b d=%h t=%h b=%b want all 0",
               out_valid, out_data, out_tag, mod_busy);
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL post_reset_ready: got %b want 1", in_ready);
    end
    mq = 64'h8F01;
  endtask

  task automatic test_known;
    int lat;
    in_valid = 1'b1;
    in_data = 32'h0001_0000;
    in_tag = 4'd3;
    tick;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 10) begin
      tick;
      lat++;
    end
    n_cmp++;
    if (lat != 3) begin
      n_bad++;
      $display("FAIL known_latency: got %0d want 3", lat);
    end
    n_cmp++;
    if (out_data !== 16'h0001 || out_tag !== 4'd3) begin
      n_bad++;
      $display("FAIL known_result: got d=%h t=%h want d=0001 t=3",
               out_data, out_tag);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    int lat;
    in_valid = 1'b1;
    in_data = 32'h0;
    in_tag = 4'd1;
    tick;
    in_data = 32'h0000_8F01;
    in_tag = 4'd2;
    tick;
    in_valid = 1'b0;
    lat = 2;
    while (out_valid !== 1'b1 && lat < 10) begin
      tick;
      lat++;
    end
    n_cmp++;
    if (lat != 3 || out_data !== 16'h0 || out_tag !== 4'd1) begin
      n_bad++;
      $display("FAIL b2b_first: got lat=%0d d=%h t=%h want 3/0000/1",
               lat, out_data, out_tag);
    end
    tick;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 16'h0 || out_tag !== 4'd2) begin
      n_bad++;
      $display("FAIL b2b_second: got v=%b d=%h t=%h want 1/0000/2",
               out_valid, out_data, out_tag);
    end
    tick;
  endtask

  task automatic test_random_stall;
    longint unsigned tv [8];
    logic [3:0] tg [8];
    logic [19:0] exp_v;
    logic [19:0] held;
    longint unsigned u;
    int sent;
    int got;
    int cyc;
    bit hold_ok;
    for (int i = 0; i < 8; i++) begin
      u = $urandom;
      tv[i] = u % (mq * mq);
      tg[i] = 4'($urandom);
    end
    exp_q.delete();
    sent = 0;
    got = 0;
    cyc = 0;
    hold_ok = 1'b0;
    held = '0;
    while (got < 8 && cyc < 200) begin
      out_ready = (cyc < 6 || cyc > 10);
      in_valid = (sent < 8);
      if (sent < 8) begin
        in_data = 32'(tv[sent]);
        in_tag = tg[sent];
      end
      #1;
      if (out_valid && !out_ready) begin
        n_cmp++;
        if (in_ready !== 1'b0) begin
          n_bad++;
          $display("FAIL stall_in_ready: got %b want 0", in_ready);
        end
        if (hold_ok) begin
          n_cmp++;
          if ({out_tag, out_data} !== held) begin
            n_bad++;
            $display("FAIL stall_hold: got %h want %h",
                     {out_tag, out_data}, held);
          end
        end
        held = {out_tag, out_data};
        hold_ok = 1'b1;
      end else begin
        hold_ok = 1'b0;
      end
      if (out_valid && out_ready) begin
        got++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL stream_extra: got %h want nothing",
                   {out_tag, out_data});
        end else begin
          exp_v = exp_q.pop_front();
          if ({out_tag, out_data} !== exp_v) begin
            n_bad++;
            $display("FAIL stream_data: got %h want %h",
                     {out_tag, out_data}, exp_v);
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({tg[sent], ref_red(tv[sent], mq)});
        sent++;
      end
      tick;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_cmp++;
    if (got != 8) begin
      n_bad++;
      $display("FAIL stream_count: got %0d want 8", got);
    end
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL stream_dup: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_mod_switch;
    longint unsigned tv [4];
    logic [19:0] exp_v;
    longint unsigned u;
    int sent;
    int got;
    int cyc;
    for (int i = 0; i < 4; i++) begin
      u = $urandom;
      tv[i] = u % (mq * mq);
    end
    exp_q.delete();
    sent = 0;
    got = 0;
    cyc = 0;
    out_ready = 1'b1;
    mod_data = 16'hC101;
    while (got < 4 && cyc < 100) begin
      in_valid = (sent < 4);
      if (sent < 4) begin
        in_data = 32'(tv[sent]);
        in_tag = 4'(sent + 8);
      end
      mod_wr = (cyc == 2);
      #1;
      if (cyc == 2) begin
        n_cmp++;
        if (in_ready !== 1'b1) begin
          n_bad++;
          $display("FAIL modsw_same_cycle: got in_ready=%b want 1", in_ready);
        end
      end
      if (cyc >= 3 && got < 3) begin
        n_cmp++;
        if (mod_busy !== 1'b1 || in_ready !== 1'b0) begin
          n_bad++;
          $display("FAIL modsw_busy: got busy=%b ready=%b want 1/0",
                   mod_busy, in_ready);
        end
      end
      if (out_valid && out_ready) begin
        got++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL modsw_extra: got %h want nothing",
                   {out_tag, out_data});
        end else begin
          exp_v = exp_q.pop_front();
          if ({out_tag, out_data} !== exp_v) begin
            n_bad++;
            $display("FAIL modsw_data: got %h want %h",
                     {out_tag, out_data}, exp_v);
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({4'(sent + 8), ref_red(tv[sent], mq)});
        sent++;
      end
      if (cyc == 2) mq = 64'hC101;
      tick;
      cyc++;
    end
    mod_wr = 1'b0;
    in_valid = 1'b0;
    n_cmp++;
    if (got != 4) begin
      n_bad++;
      $display("FAIL modsw_count: got %0d want 4", got);
    end
    n_cmp++;
    if (mod_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL modsw_busy_clear: got %b want 0", mod_busy);
    end
  endtask

  task automatic test_reset_mid;
    longint unsigned u;
    longint unsigned t;
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      u = $urandom;
      in_valid = 1'b1;
      in_data = 32'(u % (mq * mq));
      in_tag = 4'(i);
      tick;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    mq = 64'h8F01;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL rst_flush: cycle %0d got out_valid=%b want 0",
                 i, out_valid);
      end
      tick;
    end
    u = $urandom;
    t = u % (mq * mq);
    in_valid = 1'b1;
    in_data = 32'(t);
    in_tag = 4'hA;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_ready: got %b want 1", in_ready);
    end
    tick;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 10) begin
      tick;
      lat++;
    end
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== ref_red(t, mq) || out_tag !== 4'hA) begin
      n_bad++;
      $display("FAIL rst_default_mod: got v=%b d=%h t=%h want 1/%h/a",
               out_valid, out_data, out_tag, ref_red(t, mq));
    end
    tick;
  endtask

`ifdef MONT_RED_MOD_CHECK_EN
  task automatic test_mod_err;
    longint unsigned u;
    longint unsigned t;
    int lat;
    mod_wr = 1'b1;
    mod_data = 16'h8F02;
    tick;
    mod_wr = 1'b0;
    n_cmp++;
    if (mod_err !== 1'b1 || mod_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL moderr_pulse: got err=%b busy=%b want 1/0",
               mod_err, mod_busy);
    end
    tick;
    n_cmp++;
    if (mod_err !== 1'b0) begin
      n_bad++;
      $display("FAIL moderr_width: got %b want 0", mod_err);
    end
    u = $urandom;
    t = u % (mq * mq);
    in_valid = 1'b1;
    in_data = 32'(t);
    in_tag = 4'h5;
    tick;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 10) begin
      tick;
      lat++;
    end
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== ref_red(t, mq)) begin
      n_bad++;
      $display("FAIL moderr_keep_mod: got v=%b d=%h want 1/%h",
               out_valid, out_data, ref_red(t, mq));
    end
    tick;
  endtask
`endif

  initial begin
    test_reset();
    test_known();
    test_back_to_back();
    test_random_stall();
    test_mod_switch();
    test_reset_mid();
`ifdef MONT_RED_MOD_CHECK_EN
    test_mod_err();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
